// File: rtl/hub75_scan_controller.sv
// HUB75 scan controller for a 64x64, 1/32-scan panel: walks the pixel source,
// shifts upper/lower half-rows, latches, and applies BCM brightness per bit plane.
module hub75_scan_controller #(
  parameter int COLS      = 64,
  parameter int SCAN_ROWS = 32,
  parameter int BCM_BITS  = 4,
  parameter int BASE_ON   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [11:0] pixel_addr,
  input  logic [23:0] pixel_data,
  output logic        r1,
  output logic        g1,
  output logic        b1,
  output logic        r2,
  output logic        g2,
  output logic        b2,
  output logic [4:0]  row_addr,
  output logic        panel_clk,
  output logic        panel_lat,
  output logic        panel_oe_n,
  output logic        frame_start
);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, DISPLAY} state_t;

  localparam logic [5:0] COL_LAST   = 6'(COLS - 1);
  localparam logic [4:0] ROW_LAST   = 5'(SCAN_ROWS - 1);
  localparam logic [2:0] PLANE_LAST = 3'(BCM_BITS - 1);
  localparam logic [2:0] PLANE_LSB  = 3'(8 - BCM_BITS);

  state_t      state, state_nx;
  logic [5:0]  col, col_nx;
  logic [1:0]  phase, phase_nx;
  logic [2:0]  plane, plane_nx;
  logic [4:0]  row, row_nx;
  logic [15:0] cnt, cnt_nx;
  logic [15:0] on_len;
  logic [2:0]  top_bits;

  // Plane b of a channel is taken from the top BCM_BITS bits of the 8-bit value.
  function automatic logic plane_bit(input logic [7:0] chan, input logic [2:0] b);
    return chan[PLANE_LSB + b];
  endfunction

  assign on_len = 16'(BASE_ON) << plane;

  always_comb begin
    state_nx = state;
    col_nx   = col;
    phase_nx = phase;
    plane_nx = plane;
    row_nx   = row;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (enable) begin
          state_nx = SHIFT;
          col_nx   = '0;
          phase_nx = '0;
          plane_nx = '0;
          row_nx   = '0;
        end
      end
      SHIFT: begin
        phase_nx = phase + 2'd1;
        if (phase == 2'd3) begin
          if (col == COL_LAST) begin
            state_nx = BLANK;
            col_nx   = '0;
          end else begin
            col_nx = col + 6'd1;
          end
        end
      end
      BLANK: state_nx = LATCH;
      LATCH: begin
        state_nx = DISPLAY;
        cnt_nx   = '0;
      end
      DISPLAY: begin
        if (cnt == on_len - 16'd1) begin
          cnt_nx   = '0;
          col_nx   = '0;
          phase_nx = '0;
          if (plane == PLANE_LAST) begin
            plane_nx = '0;
            row_nx   = (row == ROW_LAST) ? 5'd0 : row + 5'd1;
          end else begin
            plane_nx = plane + 3'd1;
          end
          state_nx = enable ? SHIFT : IDLE;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      col         <= '0;
      phase       <= '0;
      plane       <= '0;
      row         <= '0;
      cnt         <= '0;
      top_bits    <= '0;
      pixel_addr  <= '0;
      {r1, g1, b1, r2, g2, b2} <= '0;
      row_addr    <= '0;
      panel_clk   <= 1'b0;
      panel_lat   <= 1'b0;
      panel_oe_n  <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state <= state_nx;
      col   <= col_nx;
      phase <= phase_nx;
      plane <= plane_nx;
      row   <= row_nx;
      cnt   <= cnt_nx;
      if (state_nx == SHIFT && !phase_nx[1])
        pixel_addr <= {phase_nx[0], row_nx, col_nx};
      if (state == SHIFT && phase == 2'd0)
        top_bits <= {plane_bit(pixel_data[23:16], plane),
                     plane_bit(pixel_data[15:8], plane),
                     plane_bit(pixel_data[7:0], plane)};
      if (state == SHIFT && phase == 2'd1)
        {r1, g1, b1, r2, g2, b2} <= {top_bits,
                                     plane_bit(pixel_data[23:16], plane),
                                     plane_bit(pixel_data[15:8], plane),
                                     plane_bit(pixel_data[7:0], plane)};
      if (state_nx == LATCH)
        row_addr <= row_nx;
      panel_clk   <= (state_nx == SHIFT) && (phase_nx == 2'd3);
      panel_lat   <= (state_nx == LATCH);
      panel_oe_n  <= (state_nx != DISPLAY);
      frame_start <= (state != SHIFT) && (state_nx == SHIFT) &&
                     (row_nx == 5'd0) && (plane_nx == 3'd0);
    end
  end

endmodule

// File: tb/tb_hub75_scan_controller.sv
// Directed bench for hub75_scan_controller at default parameters.
module tb_hub75_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] pixel_addr;
  logic [23:0] pixel_data;
  logic        r1, g1, b1, r2, g2, b2;
  logic [4:0]  row_addr;
  logic        panel_clk, panel_lat, panel_oe_n, frame_start;

  int n_vec  = 0;
  int n_miss = 0;

  hub75_scan_controller dut (
    .clk(clk), .rst(rst), .enable(enable),
    .pixel_addr(pixel_addr), .pixel_data(pixel_data),
    .r1(r1), .g1(g1), .b1(b1), .r2(r2), .g2(g2), .b2(b2),
    .row_addr(row_addr), .panel_clk(panel_clk), .panel_lat(panel_lat),
    .panel_oe_n(panel_oe_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Row 0: a single red dot (R=0x80) at top-half column 5; other rows: white.
  always_comb begin
    pixel_data = 24'hFFFFFF;
    if (pixel_addr[10:6] == 5'd0)
      pixel_data = (pixel_addr == 12'h005) ? 24'h800000 : 24'h000000;
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  int   k, seg, lat_total, lat_hi_cycles, last_hi;
  int   edges [8];
  int   oe_w  [8];
  int   dot_hits, dot_plane, dot_edge, bad0, bad1, overlap, rowbad, fs_at;
  int   nl, w, idle_act;
  logic prev_clk, prev_lat;

  initial begin
    // Reset values while held
    #1 rst = 1'b0;
    repeat (3) tick;
    check_vec("rst_oe_n",  panel_oe_n, 1);
    check_vec("rst_clk",   panel_clk, 0);
    check_vec("rst_lat",   panel_lat, 0);
    check_vec("rst_addr",  pixel_addr, 0);
    check_vec("rst_fs",    frame_start, 0);
    check_vec("rst_row",   row_addr, 0);
    check_vec("rst_rgb",   {r1, g1, b1, r2, g2, b2}, 0);

    // Run into SHIFT, then hit reset while panel_clk is high
    rst = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 20 && !panel_clk; i++) tick;
    check_vec("tmo_clk_hi", panel_clk, 1);
    check_vec("pre_rst_addr", pixel_addr, 12'h800);
    #2 rst = 1'b0;
    #1;
    check_vec("arst_clk",  panel_clk, 0);
    check_vec("arst_oe_n", panel_oe_n, 1);
    check_vec("arst_addr", pixel_addr, 0);
    check_vec("arst_fs",   frame_start, 0);
    tick;
    rst = 1'b1;
    tick;

    // Rows 0 and 1 statistics, then free-run to the next frame_start
    k = 0; seg = 0; lat_total = 0; lat_hi_cycles = 0; last_hi = -100;
    dot_hits = 0; dot_plane = -1; dot_edge = -1; bad0 = 0; bad1 = 0;
    overlap = 0; rowbad = 0; fs_at = -1;
    for (int i = 0; i < 8; i++) begin edges[i] = 0; oe_w[i] = 0; end
    prev_clk = 1'b0; prev_lat = 1'b0;
    while (k < 40000) begin
      if (k == 0) begin
        check_vec("fs_pulse", frame_start, 1);
        check_vec("addr_top0", pixel_addr, 12'h000);
      end
      if (k == 1) begin
        check_vec("fs_width", frame_start, 0);
        check_vec("addr_bot0", pixel_addr, 12'h800);
      end
      if (k > 0 && frame_start) begin
        fs_at = k;
        break;
      end
      if (panel_clk && !prev_clk) begin
        if (seg < 8) edges[seg]++;
        if (seg < 4) begin
          if (r1) begin dot_hits++; dot_plane = seg; dot_edge = edges[seg]; end
          if (g1 | b1 | r2 | g2 | b2) bad0++;
        end else if (seg < 8) begin
          if (!(r1 & g1 & b1 & r2 & g2 & b2)) bad1++;
        end
      end
      if (panel_clk) last_hi = k;
      if (!panel_oe_n && (panel_clk || panel_clk != prev_clk)) overlap++;
      if (!panel_oe_n && seg >= 1 && seg <= 8) oe_w[seg-1]++;
      if (panel_lat && seg < 8) lat_hi_cycles++;
      if (panel_lat && !prev_lat) begin
        if (seg < 8) begin
          check_vec($sformatf("lat_gap%0d", seg), k - last_hi, 2);
          check_vec($sformatf("lat_row%0d", seg), row_addr, seg / 4);
        end
        if (row_addr != 5'((lat_total / 4) % 32)) rowbad++;
        seg++;
        lat_total++;
      end
      prev_clk = panel_clk;
      prev_lat = panel_lat;
      tick;
      k++;
    end

    for (int i = 0; i < 8; i++) begin
      check_vec($sformatf("edges%0d", i), edges[i], 64);
      check_vec($sformatf("oe_w%0d", i), oe_w[i], 8 << (i % 4));
    end
    check_vec("lat_hi_cycles", lat_hi_cycles, 8);
    check_vec("dot_hits",  dot_hits, 1);
    check_vec("dot_plane", dot_plane, 3);
    check_vec("dot_edge",  dot_edge, 6);
    check_vec("row0_other_bits", bad0, 0);
    check_vec("row1_all_ones", bad1, 0);
    check_vec("oe_clk_overlap", overlap, 0);
    check_vec("frame_period", fs_at, 36864);
    check_vec("frame_latches", lat_total, 128);
    check_vec("row_seq", rowbad, 0);

    // Drop enable 3 cycles into the plane-2 display of the new frame
    nl = 0;
    prev_lat = panel_lat;
    for (int i = 0; i < 3000 && nl < 3; i++) begin
      tick;
      if (panel_lat && !prev_lat) begin
        nl++;
        if (nl == 1) check_vec("wrap_row", row_addr, 0);
      end
      prev_lat = panel_lat;
    end
    check_vec("tmo_lat3", nl, 3);
    for (int i = 0; i < 10 && panel_oe_n; i++) tick;
    check_vec("tmo_disp2", panel_oe_n, 0);
    w = 0;
    for (int i = 0; i < 200; i++) begin
      if (panel_oe_n) break;
      w++;
      if (w == 3) enable = 1'b0;
      tick;
    end
    check_vec("oe_w_drop", w, 32);
    idle_act = 0;
    for (int i = 0; i < 300; i++) begin
      if (panel_clk || !panel_oe_n || frame_start || panel_lat) idle_act++;
      tick;
    end
    check_vec("idle_quiet", idle_act, 0);

    // Re-enable restarts at row 0, plane 0
    enable = 1'b1;
    tick;
    check_vec("re_fs", frame_start, 1);
    check_vec("re_addr_top", pixel_addr, 12'h000);
    tick;
    check_vec("re_fs_width", frame_start, 0);
    check_vec("re_addr_bot", pixel_addr, 12'h800);
    for (int i = 0; i < 400 && !panel_lat; i++) tick;
    check_vec("tmo_re_lat", panel_lat, 1);
    check_vec("re_row", row_addr, 0);
    tick;
    w = 0;
    for (int i = 0; i < 200; i++) begin
      if (panel_oe_n) break;
      w++;
      tick;
    end
    check_vec("re_oe_w0", w, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
